// File: rtl/dnpcie_aurora_tx_arbiter.sv
// dnpcie_aurora_tx_arbiter: packet-atomic round-robin arbiter sharing one 16-bit Aurora TX lane
// Ports: aclk/reset (sync, active-high); channel_up, nfc_xoff lane status;
//   s_axis_* NUM_SRC AXI4-Stream sources (16-bit each); m_axis_* lane TX stream;
//   grant_active/grant_idx current owner; pkt_dropped/pkt_overlength event pulses.
module dnpcie_aurora_tx_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BEATS = 512
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   channel_up,
  input  logic                   nfc_xoff,
  input  logic [16*NUM_SRC-1:0]  s_axis_tdata,
  input  logic [2*NUM_SRC-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]     s_axis_tlast,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid,
  output logic [NUM_SRC-1:0]     s_axis_tready,
  output logic [15:0]            m_axis_tdata,
  output logic [1:0]             m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   grant_active,
  output logic [2:0]             grant_idx,
  output logic                   pkt_dropped,
  output logic                   pkt_overlength
);
  typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d, pick, idx;
  logic [15:0] cnt_q, cnt_d;
  logic        dropped_q, dropped_d, overlen_q, overlen_d;
  logic [7:0]  vld, lst;
  logic [127:0] dat;
  logic [15:0] kp;
  logic        g_vld, g_lst, at_max, pass;
  // Sources are zero-padded to the 8-source maximum so grant_q indexes them directly.
  assign vld = 8'(s_axis_tvalid);
  assign lst = 8'(s_axis_tlast);
  assign dat = 128'(s_axis_tdata);
  assign kp  = 16'(s_axis_tkeep);
  // Round-robin search from grant_q+1; iterating downward lets the nearest requester win.
  always_comb begin
    g_vld  = vld[grant_q];
    g_lst  = lst[grant_q];
    at_max = cnt_q == 16'(MAX_BEATS - 1);
    pick   = grant_q;
    idx    = grant_q;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = 3'((32'(grant_q) + k) % NUM_SRC);
      if (vld[idx]) pick = idx;
    end
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 3'(NUM_SRC - 1);
      cnt_q     <= '0;
      dropped_q <= 1'b0;
      overlen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
      overlen_q <= overlen_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    dropped_d = 1'b0;
    overlen_d = 1'b0;
    case (state_q)
      IDLE:
        if (channel_up && !nfc_xoff && |s_axis_tvalid) begin
          state_d = PASS;
          grant_d = pick;
          cnt_d   = '0;
        end
      PASS:
        if (!channel_up) begin
          state_d   = FLUSH;
          dropped_d = 1'b1;
        end else if (g_vld && m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (g_lst) state_d = IDLE;
          else if (at_max) begin
            state_d   = FLUSH;
            overlen_d = 1'b1;
          end
        end
      FLUSH:
        if (g_vld && g_lst) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end
  // Link loss blanks the lane in the same cycle it is seen.
  always_comb begin
    pass           = state_q == PASS && channel_up;
    m_axis_tvalid  = pass & g_vld;
    m_axis_tlast   = pass & (g_lst | at_max);
    m_axis_tdata   = pass ? dat[{grant_q, 4'b0} +: 16] : 16'd0;
    m_axis_tkeep   = pass ? kp[{grant_q, 1'b0} +: 2] : 2'd0;
    s_axis_tready  = {{(NUM_SRC-1){1'b0}}, pass ? m_axis_tready : state_q == FLUSH} << grant_q;
    grant_active   = state_q != IDLE;
    grant_idx      = grant_q;
    pkt_dropped    = dropped_q;
    pkt_overlength = overlen_q;
  end
endmodule
